// File: rtl/nios_system_mem_test_pkg.sv
// Shared types and constants for the on-chip memory test master.
// The pattern step is the 32-bit golden-ratio constant, so consecutive words differ in many bits.
package nios_system_mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] PATTERN_STEP = 32'h9E3779B9;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic bit read_latency_ok(input int lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/nios_system_mem_test_master_if.sv
// Avalon-MM bus between the memory test master and the on-chip memory slave.
interface nios_system_mem_test_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Handshake: a transfer is accepted in every cycle where avm_chipselect=1 and
  // avm_waitrequest=0; while avm_waitrequest=1 the master holds address, data and strobes.
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic                avm_read;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_clken;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_read,
    output avm_byteenable,
    output avm_clken,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write,
    input  avm_read,
    input  avm_byteenable,
    input  avm_clken,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/nios_system_mem_test_rdpipe.sv
// Shift pipe carrying expected data and address for each accepted read, DEPTH cycles deep,
// so the head lines up with the slave's readdata for that read.
module nios_system_mem_test_rdpipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pending
);

  logic [DEPTH-1:0]  vld_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= push;
      data_q[0] <= push_data;
      addr_q[0] <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];

  // Entries still in flight behind the head; the head itself is compared this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | vld_q[i];
    end
  end

endmodule

// File: rtl/nios_system_mem_test_master.sv
// Memory test master: writes an accumulator-generated pattern over a word range, reads it
// back through a latency-matched pipe and reports error count and first failing address.
module nios_system_mem_test_master
  import nios_system_mem_test_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output state_t              dbg_state,
  nios_system_mem_test_master_if.master avm
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end

  localparam logic [ADDR_W:0]   IDX_ONE = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] STEP    = DATA_W'(PATTERN_STEP);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat;
  logic              result_vld;
  logic              accept;
  logic              last;
  logic              launch;
  logic [ADDR_W-1:0] cur_addr;
  logic              pipe_vld;
  logic              pipe_pending;
  logic [DATA_W-1:0] pipe_data;
  logic [ADDR_W-1:0] pipe_addr;

  // Address arithmetic is ADDR_W wide, so the range wraps from the top word to 0.
  assign cur_addr = base_q + idx[ADDR_W-1:0];
  assign last     = (idx == count_q - IDX_ONE);
  assign launch   = (state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    avm.avm_chipselect = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_read       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write      = 1'b1;
        if (!avm.avm_waitrequest && last) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_read       = 1'b1;
        if (!avm.avm_waitrequest && last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pipe_pending) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign accept             = avm.avm_chipselect & ~avm.avm_waitrequest;
  assign avm.avm_address    = avm.avm_chipselect ? cur_addr : '0;
  assign avm.avm_writedata  = avm.avm_write ? pat : '0;
  assign avm.avm_byteenable = '1;
  assign avm.avm_clken      = 1'b1;

  // Datapath: index/pattern accumulator, result counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q         <= '0;
      count_q        <= '0;
      seed_q         <= '0;
      idx            <= '0;
      pat            <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      result_vld     <= 1'b0;
    end else if (launch) begin
      base_q         <= base_addr;
      count_q        <= word_count;
      seed_q         <= seed;
      idx            <= '0;
      pat            <= seed;
      err_count      <= '0;
      first_err_addr <= '0;
      result_vld     <= 1'b0;
    end else begin
      if (accept) begin
        // Rewind after the last write so the read phase regenerates the same sequence.
        if (last) begin
          idx <= '0;
          pat <= seed_q;
        end else begin
          idx <= idx + IDX_ONE;
          pat <= pat + STEP;
        end
      end
      if (pipe_vld && (avm.avm_readdata != pipe_data)) begin
        err_count <= err_count + IDX_ONE;
        if (err_count == '0) begin
          first_err_addr <= pipe_addr;
        end
      end
      if (state == ST_DONE) begin
        result_vld <= 1'b1;
      end
    end
  end

  nios_system_mem_test_rdpipe #(
    .DEPTH  (READ_LATENCY),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rdpipe (
    .clk       (clk),
    .reset     (reset),
    .push      (accept & avm.avm_read),
    .push_data (pat),
    .push_addr (cur_addr),
    .out_vld   (pipe_vld),
    .out_data  (pipe_data),
    .out_addr  (pipe_addr),
    .pending   (pipe_pending)
  );

  assign busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign pass      = (result_vld || (state == ST_DONE)) && (err_count == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_nios_system_mem_test_master.sv
// Bench for the memory test master: memory slave models with fault/stall injection and a
// pattern/timing reference model computed directly from the test rules.
module tb_nios_system_mem_test_master;
  import nios_system_mem_test_pkg::*;

  localparam logic [31:0] STEP = 32'h9E3779B9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t0 = 0;
  logic busy_c1;

  // DUT 1: READ_LATENCY = 1
  logic        start1;
  logic [9:0]  base1;
  logic [10:0] count1;
  logic [31:0] seed1;
  logic        busy1, done1, pass1;
  logic [10:0] err1;
  logic [9:0]  ferr1;
  state_t      dbg1;
  nios_system_mem_test_master_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();

  nios_system_mem_test_master #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base1), .word_count(count1),
    .seed(seed1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_addr(ferr1), .dbg_state(dbg1), .avm(bus1.master)
  );

  // DUT 2: READ_LATENCY = 2
  logic        start2;
  logic [9:0]  base2;
  logic [10:0] count2;
  logic [31:0] seed2;
  logic        busy2, done2, pass2;
  logic [10:0] err2;
  logic [9:0]  ferr2;
  state_t      dbg2;
  nios_system_mem_test_master_if #(.ADDR_W(10), .DATA_W(32)) bus2 ();

  nios_system_mem_test_master #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base2), .word_count(count2),
    .seed(seed2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_addr(ferr2), .dbg_state(dbg2), .avm(bus2.master)
  );

  // Memory slave models with optional single-address bit-0 fault on reads.
  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic [31:0] rd1_q, rd2_a, rd2_b;
  logic        fault1_en = 1'b0, fault2_en = 1'b0;
  logic [9:0]  fault1_addr = '0, fault2_addr = '0;
  logic [9:0]  wr_addr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_data_q[$];
  logic [9:0]  rd_addr_q[$];
  int cs_cnt1 = 0;
  int wr_cnt2 = 0;

  always @(posedge clk) begin
    if (bus1.avm_chipselect) cs_cnt1++;
    if (bus1.avm_chipselect && !bus1.avm_waitrequest) begin
      if (bus1.avm_write) begin
        mem1[bus1.avm_address] <= bus1.avm_writedata;
        wr_addr_q.push_back(bus1.avm_address);
        wr_data_q.push_back(bus1.avm_writedata);
      end
      if (bus1.avm_read) rd_addr_q.push_back(bus1.avm_address);
    end
    if (bus1.avm_chipselect && !bus1.avm_waitrequest && bus1.avm_read)
      rd1_q <= mem1[bus1.avm_address] ^ {31'b0, fault1_en && (bus1.avm_address == fault1_addr)};
    else
      rd1_q <= '0;
  end
  assign bus1.avm_readdata = rd1_q;

  always @(posedge clk) begin
    if (bus2.avm_chipselect && !bus2.avm_waitrequest && bus2.avm_write) begin
      mem2[bus2.avm_address] <= bus2.avm_writedata;
      wr_cnt2++;
    end
    if (bus2.avm_chipselect && !bus2.avm_waitrequest && bus2.avm_read)
      rd2_a <= mem2[bus2.avm_address] ^ {31'b0, fault2_en && (bus2.avm_address == fault2_addr)};
    else
      rd2_a <= '0;
    rd2_b <= rd2_a;
  end
  assign bus2.avm_readdata = rd2_b;

  // Reference: pattern word i of a test
  function automatic logic [31:0] pat_word(input logic [31:0] s, input int i);
    return s + (32'(i) * STEP);
  endfunction

  function automatic void build_expected(input logic [31:0] s, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(pat_word(s, i));
  endfunction

  task automatic launch(input logic [9:0] b, input logic [10:0] n, input logic [31:0] s);
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    cs_cnt1 = 0;
    base1 = b; count1 = n; seed1 = s; start1 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    busy_c1 = busy1;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    dc = (done1 === 1'b1) ? (cyc - t0) : -1;
  endtask

  task automatic test_reset_values();
    repeat (3) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 || err1 !== '0 || ferr1 !== '0) begin
      failures++;
      $display("FAIL reset_status got busy=%b done=%b pass=%b err=%0d ferr=%0d exp all 0", busy1, done1, pass1, err1, ferr1);
    end
    checks++;
    if (bus1.avm_chipselect !== 1'b0 || bus1.avm_write !== 1'b0 || bus1.avm_read !== 1'b0 ||
        bus1.avm_address !== '0 || bus1.avm_writedata !== '0) begin
      failures++;
      $display("FAIL reset_bus got cs=%b wr=%b rd=%b addr=%0h wd=%0h exp all 0", bus1.avm_chipselect, bus1.avm_write, bus1.avm_read, bus1.avm_address, bus1.avm_writedata);
    end
    checks++;
    if (bus1.avm_byteenable !== 4'hF || bus1.avm_clken !== 1'b1) begin
      failures++;
      $display("FAIL reset_fixed got be=%0h clken=%b exp f 1", bus1.avm_byteenable, bus1.avm_clken);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc;
    logic [31:0] golden [4];
    golden[0] = 32'h00000000; golden[1] = 32'h9E3779B9;
    golden[2] = 32'h3C6EF372; golden[3] = 32'hDAA66D2B;
    launch(10'd0, 11'd4, 32'd0);
    wait_done(100, dc);
    checks++;
    if (dc != 10 || busy1 !== 1'b0 || busy_c1 !== 1'b1) begin
      failures++;
      $display("FAIL basic_timing got done_cyc=%0d busy_at_done=%b busy_c1=%b exp 10 0 1", dc, busy1, busy_c1);
    end
    checks++;
    if (pass1 !== 1'b1 || err1 !== '0) begin
      failures++;
      $display("FAIL basic_result got pass=%b err=%0d exp 1 0", pass1, err1);
    end
    checks++;
    if (wr_data_q.size() != 4 || rd_addr_q.size() != 4) begin
      failures++;
      $display("FAIL basic_count got wr=%0d rd=%0d exp 4 4", wr_data_q.size(), rd_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_data_q[i] !== golden[i] || wr_addr_q[i] !== 10'(i) || rd_addr_q[i] !== 10'(i)) begin
          failures++;
          $display("FAIL basic_word%0d got wa=%0d wd=%h ra=%0d exp %0d %h %0d", i, wr_addr_q[i], wr_data_q[i], rd_addr_q[i], i, golden[i], i);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (pass1 !== 1'b1 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL basic_pass_hold got pass=%b done=%b exp 1 0", pass1, done1);
    end
  endtask

  task automatic test_wrap();
    int dc;
    logic [9:0] ea [4];
    ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0; ea[3] = 10'd1;
    launch(10'd1022, 11'd4, $urandom);
    wait_done(100, dc);
    checks++;
    if (dc != 10 || pass1 !== 1'b1 || wr_addr_q.size() != 4 || rd_addr_q.size() != 4) begin
      failures++;
      $display("FAIL wrap_result got done_cyc=%0d pass=%b wr=%0d rd=%0d exp 10 1 4 4", dc, pass1, wr_addr_q.size(), rd_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== ea[i] || rd_addr_q[i] !== ea[i]) begin
          failures++;
          $display("FAIL wrap_addr%0d got wa=%0d ra=%0d exp %0d", i, wr_addr_q[i], rd_addr_q[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_fault();
    int dc;
    fault1_addr = 10'd5; fault1_en = 1'b1;
    launch(10'd0, 11'd16, $urandom);
    wait_done(200, dc);
    checks++;
    if (dc != 34 || err1 !== 11'd1 || ferr1 !== 10'd5 || pass1 !== 1'b0) begin
      failures++;
      $display("FAIL fault_result got done_cyc=%0d err=%0d ferr=%0d pass=%b exp 34 1 5 0", dc, err1, ferr1, pass1);
    end
    fault1_en = 1'b0;
  endtask

  task automatic test_stall();
    int nwr, nrd, left, n, dc;
    bit ws, rs;
    logic [9:0] ha;
    logic [31:0] hd, s;
    logic hw, hr;
    s = $urandom;
    build_expected(s, 8);
    launch(10'd40, 11'd8, s);
    nwr = 0; nrd = 0; left = 0; n = 0; ws = 0; rs = 0;
    ha = '0; hd = '0; hw = 0; hr = 0;
    while (done1 !== 1'b1 && n < 200) begin
      if (left > 0) begin
        checks++;
        if (bus1.avm_address !== ha || bus1.avm_writedata !== hd || bus1.avm_write !== hw ||
            bus1.avm_read !== hr || bus1.avm_chipselect !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold got a=%0d d=%h w=%b r=%b exp %0d %h %b %b", bus1.avm_address, bus1.avm_writedata, bus1.avm_write, bus1.avm_read, ha, hd, hw, hr);
        end
        left--;
        if (left == 0) bus1.avm_waitrequest = 1'b0;
      end else if ((bus1.avm_write && nwr == 1 && !ws) || (bus1.avm_read && nrd == 2 && !rs)) begin
        if (bus1.avm_write) ws = 1; else rs = 1;
        bus1.avm_waitrequest = 1'b1;
        left = 3;
        ha = bus1.avm_address; hd = bus1.avm_writedata; hw = bus1.avm_write; hr = bus1.avm_read;
      end
      if (bus1.avm_chipselect && !bus1.avm_waitrequest) begin
        if (bus1.avm_write) nwr++;
        else if (bus1.avm_read) nrd++;
      end
      @(negedge clk);
      n++;
    end
    dc = (done1 === 1'b1) ? (cyc - t0) : -1;
    checks++;
    if (dc != 24 || pass1 !== 1'b1 || err1 !== '0 || !ws || !rs) begin
      failures++;
      $display("FAIL stall_result got done_cyc=%0d pass=%b err=%0d ws=%b rs=%b exp 24 1 0 1 1", dc, pass1, err1, ws, rs);
    end
    checks++;
    if (wr_data_q.size() != 8 || wr_data_q[1] !== exp_q[1] || wr_addr_q[1] !== 10'd41 || wr_data_q[7] !== exp_q[7]) begin
      failures++;
      $display("FAIL stall_writes got n=%0d", wr_data_q.size());
    end
    bus1.avm_waitrequest = 1'b0;
  endtask

  task automatic test_zero_count();
    int dc;
    launch(10'd7, 11'd0, $urandom);
    wait_done(10, dc);
    checks++;
    if (dc != 1 || busy_c1 !== 1'b0 || pass1 !== 1'b1 || err1 !== '0) begin
      failures++;
      $display("FAIL zero_count got done_cyc=%0d busy=%b pass=%b err=%0d exp 1 0 1 0", dc, busy_c1, pass1, err1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cs_cnt1 != 0) begin
      failures++;
      $display("FAIL zero_count_bus got cs_cycles=%0d exp 0", cs_cnt1);
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    logic [31:0] s;
    s = $urandom;
    launch(10'd100, 11'd8, s);
    @(negedge clk);
    base1 = 10'd0; count1 = 11'd2; seed1 = ~s; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(200, dc);
    checks++;
    if (dc != 18 || pass1 !== 1'b1 || wr_data_q.size() != 8) begin
      failures++;
      $display("FAIL busy_start got done_cyc=%0d pass=%b writes=%0d exp 18 1 8", dc, pass1, wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 10'd100 || wr_data_q[7] !== pat_word(s, 7)) begin
        failures++;
        $display("FAIL busy_start_data got a0=%0d d7=%h exp 100 %h", wr_addr_q[0], wr_data_q[7], pat_word(s, 7));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int dc;
    launch(10'd0, 11'd16, $urandom);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.avm_chipselect !== 1'b0 || bus1.avm_write !== 1'b0 || bus1.avm_read !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got cs=%b wr=%b rd=%b busy=%b done=%b exp all 0", bus1.avm_chipselect, bus1.avm_write, bus1.avm_read, busy1, done1);
    end
    reset = 1'b0;
    launch(10'd300, 11'd16, $urandom);
    wait_done(200, dc);
    checks++;
    if (dc != 34 || pass1 !== 1'b1 || err1 !== '0 || wr_data_q.size() != 16) begin
      failures++;
      $display("FAIL reset_restart got done_cyc=%0d pass=%b err=%0d writes=%0d exp 34 1 0 16", dc, pass1, err1, wr_data_q.size());
    end
  endtask

  task automatic test_random();
    int dc, n, hit_off, exp_err;
    logic [9:0] b, exp_ferr;
    logic [31:0] s;
    for (int it = 0; it < 8; it++) begin
      b = 10'($urandom_range(0, 1023));
      n = $urandom_range(1, 40);
      s = $urandom;
      hit_off = $urandom_range(0, 1) ? $urandom_range(0, n - 1) : n;
      fault1_addr = 10'((32'(b) + 32'(hit_off)) % 1024);
      fault1_en = 1'b1;
      exp_err = 0; exp_ferr = '0;
      for (int i = 0; i < n; i++) begin
        if (10'((32'(b) + 32'(i)) % 1024) == fault1_addr) begin
          if (exp_err == 0) exp_ferr = fault1_addr;
          exp_err++;
        end
      end
      build_expected(s, n);
      launch(b, 11'(n), s);
      wait_done(300, dc);
      checks++;
      if (dc != 2 * n + 2 || err1 !== 11'(exp_err) || ferr1 !== exp_ferr || pass1 !== (exp_err == 0)) begin
        failures++;
        $display("FAIL random%0d got done_cyc=%0d err=%0d ferr=%0d pass=%b exp %0d %0d %0d %b", it, dc, err1, ferr1, pass1, 2 * n + 2, exp_err, exp_ferr, exp_err == 0);
      end
      checks++;
      if (wr_data_q.size() != n || rd_addr_q.size() != n) begin
        failures++;
        $display("FAIL random%0d_len got wr=%0d rd=%0d exp %0d", it, wr_data_q.size(), rd_addr_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== 10'((32'(b) + 32'(i)) % 1024) || rd_addr_q[i] !== wr_addr_q[i]) begin
            failures++;
            $display("FAIL random%0d_word%0d got wa=%0d wd=%h ra=%0d exp %0d %h", it, i, wr_addr_q[i], wr_data_q[i], rd_addr_q[i], (32'(b) + 32'(i)) % 1024, exp_q[i]);
          end
        end
      end
    end
    fault1_en = 1'b0;
  endtask

  task automatic test_latency2();
    int n, dc, bad;
    logic [9:0] b;
    logic [31:0] s;
    b = 10'($urandom_range(0, 1023));
    s = $urandom;
    @(negedge clk);
    wr_cnt2 = 0;
    base2 = b; count2 = 11'd1024; seed2 = s; start2 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    dc = (done2 === 1'b1) ? (cyc - t0) : -1;
    checks++;
    if (dc != 2051 || busy2 !== 1'b0 || pass2 !== 1'b1 || err2 !== '0 || wr_cnt2 != 1024) begin
      failures++;
      $display("FAIL lat2_full got done_cyc=%0d busy=%b pass=%b err=%0d writes=%0d exp 2051 0 1 0 1024", dc, busy2, pass2, err2, wr_cnt2);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem2[(32'(b) + 32'(i)) % 1024] !== pat_word(s, i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL lat2_mem got bad_words=%0d exp 0", bad);
    end
    fault2_addr = 10'd503; fault2_en = 1'b1;
    @(negedge clk);
    base2 = 10'd500; count2 = 11'd10; seed2 = $urandom; start2 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    dc = (done2 === 1'b1) ? (cyc - t0) : -1;
    checks++;
    if (dc != 23 || err2 !== 11'd1 || ferr2 !== 10'd503 || pass2 !== 1'b0) begin
      failures++;
      $display("FAIL lat2_fault got done_cyc=%0d err=%0d ferr=%0d pass=%b exp 23 1 503 0", dc, err2, ferr2, pass2);
    end
    fault2_en = 1'b0;
  endtask

  initial begin
    start1 = 1'b0; base1 = '0; count1 = '0; seed1 = '0;
    start2 = 1'b0; base2 = '0; count2 = '0; seed2 = '0;
    bus1.avm_waitrequest = 1'b0;
    bus2.avm_waitrequest = 1'b0;
    test_reset_values();
    test_basic();
    test_wrap();
    test_fault();
    test_stall();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_write();
    test_random();
    test_latency2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_system_mem_test_master.md
# nios_system_mem_test_master

Avalon-MM master that exercises the 1024×32 on-chip memory slave from the other end of its port. On a start pulse it writes a deterministic pattern over a word range, reads the range back, and reports pass/fail with error count and first failing address. It sits beside the Nios II data master on the system interconnect and serves as a power-on and board-bring-up memory test.

## Interface
Parameters:
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width
- READ_LATENCY, 1, fixed slave read latency in cycles; legal values are 1 and 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse, honoured only when idle
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  words to test (0..1024)
- seed  in  DATA_W  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result of last test (valid from done until the next start)
- err_count  out  ADDR_W+1  mismatching words in last test
- first_err_addr  out  ADDR_W  address of the first mismatch
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  transfer request
- avm_write  out  1  write strobe
- avm_read  out  1  read strobe
- avm_byteenable  out  DATA_W/8  fixed all-ones
- avm_clken  out  1  fixed 1
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall; tie to 0 for the on-chip memory

## Operation
- States: IDLE → WRITE → READ → DRAIN → DONE → IDLE.
- Pattern word i = seed + i·32'h9E3779B9 mod 2^32, generated with an accumulator. No multiplier.
- Address i = (base_addr + i) mod 2^ADDR_W. The range wraps past 1023 to 0.
- A transfer is accepted in any cycle where chipselect is high and waitrequest is low.
- While waitrequest is high, address, data and strobes hold stable.
- **WRITE:** one write per accepted cycle for i = 0..N-1. After the last accept, reset the index and the pattern, then go to READ.
- **READ:** one read per accepted cycle. Each accepted read pushes its expected word and address into a pipe of depth READ_LATENCY.
- **DRAIN:** no requests. Wait until the pipe is empty.
- **Compare:** avm_readdata is compared against the pipe output exactly READ_LATENCY cycles after the read was accepted.
  - On mismatch, err_count increments.
  - On the first mismatch, first_err_addr is captured.
- **DONE:** done=1 for one cycle. pass = (err_count == 0). Return to IDLE.
- **word_count = 0:** go IDLE → DONE directly with no bus activity, pass=1, err_count=0.
- **start while busy:** ignored.
- **start from IDLE:** clears err_count and first_err_addr.
- **reset, including mid-test:** all outputs go to 0 except avm_byteenable (all ones) and avm_clken (1). The bus is idle immediately. The pipe is cleared.

## Timing
- start is sampled on cycle 0. busy is high from cycle 1 until done.
- With no stalls and N>0:
  - writes occupy cycles 1..N
  - reads occupy cycles N+1..2N
  - the last compare happens in cycle 2N+READ_LATENCY
  - done is high in cycle 2N+READ_LATENCY+1, with busy low in that same cycle
- Each stall cycle adds one cycle to total latency.
- word_count=0: done is in cycle 1.
- Throughput is one transfer per cycle with no bubble between WRITE and READ.

## Structure
- Package nios_system_mem_test_pkg holds:
  - the state enum
  - PATTERN_STEP = 32'h9E3779B9
  - the legal READ_LATENCY range check
- Sub-module nios_system_mem_test_rdpipe: a READ_LATENCY-deep valid/expected-data/address shift pipe with async clear.

## Test plan
- **Reset:** assert reset mid-WRITE → next cycle all bus strobes are 0, busy=0, done=0. A fresh start then completes normally.
- **Basic:** base=0, count=4, seed=0, latency 1, ideal memory model.
  - Writes 0, 9E3779B9, 3C6EF372, DAA66D2B to addresses 0..3.
  - done in cycle 10, pass=1, err_count=0.
- **Wrap:** base=1022, count=4 → addresses 1022, 1023, 0, 1 in both phases. pass=1.
- **Fault:** model forces bit 0 of readdata at address 5 (base=0, count=16) → err_count=1, first_err_addr=5, pass=0.
- **Stall:** waitrequest high for 3 cycles on the 2nd write and the 3rd read → outputs held stable, done 6 cycles later than unstalled, pass=1.
- **Edges:** count=0 → done in cycle 1, no chipselect. A start pulse during busy → no effect. count=1024 with READ_LATENCY=2 → done in cycle 2051.
